cdb_slot_scheduler: RTL and testbench

- Issue-stage arbiter that owns the Common Data Bus schedule.
- Each cycle it grants at most one single-cycle requester (integer ALU or load/store buffer) the current CDB slot.
- It reserves future CDB slots for the fixed-latency pipelined multiplier and the non-pipelined divider.
- Its outputs drive Iss_Int and Iss_Lsb into the CDB directly, and issue-enable into the mul/div queues, so Iss_Int, Iss_Lsb, Mul_Done and Div_Done are never asserted together.

---
 rtl/cdb_slot_scheduler_pkg.sv | 19 +
 rtl/cdb_slot_scheduler_if.sv | 30 +++
 rtl/cdb_rr_arb2.sv | 34 +++
 rtl/cdb_slot_scheduler.sv | 74 +++++++
 tb/tb_cdb_slot_scheduler.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/cdb_slot_scheduler_pkg.sv
// Shared constants and types for the CDB slot scheduler.
package cdb_slot_scheduler_pkg;

  localparam int unsigned MulLatDefault = 4;
  localparam int unsigned DivLatDefault = 7;

  // Requester index, ordered as the CDB select mux expects.
  typedef enum logic [1:0] {
    ReqInt = 2'd0,
    ReqLsb = 2'd1,
    ReqMul = 2'd2,
    ReqDiv = 2'd3
  } cdb_req_e;

  function automatic int unsigned slotWidth(input int unsigned divLat);
    return divLat + 1;
  endfunction

endpackage

// File: rtl/cdb_slot_scheduler_if.sv
// Request/grant bundle between the issue queues and the CDB slot scheduler.
interface cdb_slot_scheduler_if;

  logic IntQ_Ready;
  logic LsbQ_Ready;
  logic MulQ_Ready;
  logic DivQ_Ready;
  logic Cdb_Flush;
  logic Mul_Done;
  logic Div_Done;
  logic Iss_Int;
  logic Iss_Lsb;
  logic Iss_Mul;
  logic Iss_Div;
  logic Div_Busy;
  logic Sched_Err;

  // Scheduler side.
  modport master (
    input  IntQ_Ready, LsbQ_Ready, MulQ_Ready, DivQ_Ready, Cdb_Flush, Mul_Done, Div_Done,
    output Iss_Int, Iss_Lsb, Iss_Mul, Iss_Div, Div_Busy, Sched_Err
  );

  // Queue / execution-unit side.
  modport slave (
    output IntQ_Ready, LsbQ_Ready, MulQ_Ready, DivQ_Ready, Cdb_Flush, Mul_Done, Div_Done,
    input  Iss_Int, Iss_Lsb, Iss_Mul, Iss_Div, Div_Busy, Sched_Err
  );

endinterface

// File: rtl/cdb_rr_arb2.sv
// Two-requester round-robin arbiter for the integer ALU and load/store buffer.
module cdb_rr_arb2 (
  input  logic Clk,
  input  logic Resetb,
  input  logic en_i,
  input  logic intReq_i,
  input  logic lsbReq_i,
  output logic intGnt_o,
  output logic lsbGnt_o
);

  logic rrQ, rrD;

  // rrQ=1 prefers Lsb; the last winner loses the next contended cycle.
  always_comb begin
    intGnt_o = en_i & intReq_i & (~lsbReq_i | ~rrQ);
    lsbGnt_o = en_i & lsbReq_i & (~intReq_i | rrQ);
    rrD      = rrQ;
    if (intGnt_o) begin
      rrD = 1'b1;
    end else if (lsbGnt_o) begin
      rrD = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      rrQ <= 1'b0;
    end else begin
      rrQ <= rrD;
    end
  end

endmodule

// File: rtl/cdb_slot_scheduler.sv
// Owns the CDB schedule: grants the current slot to Int/Lsb and books future
// slots for the fixed-latency multiplier and divider.
module cdb_slot_scheduler
  import cdb_slot_scheduler_pkg::*;
#(
  parameter int unsigned MUL_LAT = MulLatDefault,
  parameter int unsigned DIV_LAT = DivLatDefault
) (
  input logic                  Clk,
  input logic                  Resetb,
  cdb_slot_scheduler_if.master bus
);

  localparam int unsigned SLOT_W = slotWidth(DIV_LAT);
  localparam int unsigned CntW   = $clog2(DIV_LAT);

  logic [SLOT_W-1:0] slotQ, slotD;
  logic [CntW-1:0]   divCntQ, divCntD;
  logic              errQ, errD;
  logic              issMul, issDiv, arbEn;

  // Grants are forced low while reset is held, independent of registered state.
  always_comb begin
    issMul = Resetb & bus.MulQ_Ready & ~slotQ[MUL_LAT];
    issDiv = Resetb & bus.DivQ_Ready & (divCntQ == '0) & ~slotQ[DIV_LAT];
    arbEn  = Resetb & ~slotQ[0] & ~bus.Cdb_Flush;
  end

  cdb_rr_arb2 u_arb (
    .Clk      (Clk),
    .Resetb   (Resetb),
    .en_i     (arbEn),
    .intReq_i (bus.IntQ_Ready),
    .lsbReq_i (bus.LsbQ_Ready),
    .intGnt_o (bus.Iss_Int),
    .lsbGnt_o (bus.Iss_Lsb)
  );

  always_comb begin
    slotD = (slotQ >> 1)
          | (SLOT_W'(issMul) << (MUL_LAT - 1))
          | (SLOT_W'(issDiv) << (DIV_LAT - 1));

    divCntD = divCntQ;
    if (issDiv) begin
      divCntD = CntW'(DIV_LAT - 1);
    end else if (divCntQ != '0) begin
      divCntD = divCntQ - CntW'(1);
    end

    // A completion must land exactly on a booked slot, and never two at once.
    errD = errQ
         | ((bus.Mul_Done | bus.Div_Done) != slotQ[0])
         | (bus.Mul_Done & bus.Div_Done);
  end

  always_ff @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      slotQ   <= '0;
      divCntQ <= '0;
      errQ    <= 1'b0;
    end else begin
      slotQ   <= slotD;
      divCntQ <= divCntD;
      errQ    <= errD;
    end
  end

  assign bus.Iss_Mul   = issMul;
  assign bus.Iss_Div   = issDiv;
  assign bus.Div_Busy  = (divCntQ != '0);
  assign bus.Sched_Err = errQ;

endmodule

// File: tb/tb_cdb_slot_scheduler.sv
// Scoreboard bench: stimulus pushes model expectations, a negedge monitor compares.
module tb_cdb_slot_scheduler;

  localparam int MulLat = 4;
  localparam int DivLat = 7;

  logic Clk = 1'b0;
  logic Resetb = 1'b0;
  always #5 Clk = ~Clk;

  cdb_slot_scheduler_if bus ();

  cdb_slot_scheduler u_dut (
    .Clk    (Clk),
    .Resetb (Resetb),
    .bus    (bus)
  );

  typedef struct {
    logic [5:0] v;   // {Iss_Int, Iss_Lsb, Iss_Mul, Iss_Div, Div_Busy, Sched_Err}
    int         t;
  } exp_t;

  exp_t sbq[$];
  int   nVec = 0;
  int   nMis = 0;

  // Reference model: absolute-time booking table (1 = mul, 2 = div).
  int ownerMap[int];
  int mt = 0;
  bit mDivIssued = 0;
  int mDivT = 0;
  bit mPrefLsb = 0;
  bit mErr = 0;

  function automatic int ownerAt(input int t);
    return ownerMap.exists(t) ? ownerMap[t] : 0;
  endfunction

  task automatic step(input bit rst, input bit iq, input bit lq, input bit mq, input bit dq,
                      input bit fl, input bit inj);
    int   own0;
    bit   busy, gm, gd, gi, gl, free, md, dd;
    exp_t e;
    @(posedge Clk);
    #1;
    Resetb = rst;
    bus.IntQ_Ready = iq;
    bus.LsbQ_Ready = lq;
    bus.MulQ_Ready = mq;
    bus.DivQ_Ready = dq;
    bus.Cdb_Flush  = fl;
    if (!rst) begin
      ownerMap.delete();
      mDivIssued = 0;
      mPrefLsb   = 0;
      mErr       = 0;
      md = 0;
      dd = 0;
      e.v = '0;
    end else begin
      own0 = ownerAt(mt);
      md   = (own0 == 1) ^ inj;
      dd   = (own0 == 2);
      busy = mDivIssued && (mt - mDivT) < DivLat;
      gm   = mq && ownerAt(mt + MulLat) == 0;
      gd   = dq && !busy && ownerAt(mt + DivLat) == 0;
      if (gm) ownerMap[mt + MulLat] = 1;
      if (gd) begin
        ownerMap[mt + DivLat] = 2;
        mDivIssued = 1;
        mDivT = mt;
      end
      free = (own0 == 0) && !fl;
      gi   = free && iq && (!lq || !mPrefLsb);
      gl   = free && lq && (!iq || mPrefLsb);
      if (gi) mPrefLsb = 1;
      else if (gl) mPrefLsb = 0;
      e.v  = {gi, gl, gm, gd, busy, mErr};
      if (((md || dd) != (own0 != 0)) || (md && dd)) mErr = 1;
      ownerMap.delete(mt);
    end
    bus.Mul_Done = md;
    bus.Div_Done = dd;
    e.t = mt;
    mt++;
    sbq.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents a full output vector.
  always @(negedge Clk) begin
    if (sbq.size() > 0) begin
      exp_t x;
      logic [5:0] act;
      x   = sbq.pop_front();
      act = {bus.Iss_Int, bus.Iss_Lsb, bus.Iss_Mul, bus.Iss_Div, bus.Div_Busy, bus.Sched_Err};
      nVec++;
      if (act !== x.v) begin
        nMis++;
        $display("FAIL cyc%0d int/lsb/mul/div/busy/err got %b want %b", x.t, act, x.v);
      end
    end
  end

  initial begin
    bus.IntQ_Ready = 0;
    bus.LsbQ_Ready = 0;
    bus.MulQ_Ready = 0;
    bus.DivQ_Ready = 0;
    bus.Cdb_Flush  = 0;
    bus.Mul_Done   = 0;
    bus.Div_Done   = 0;

    repeat (2) step(0, 1, 1, 1, 1, 0, 0);               // reset: all grants low
    repeat (3) step(1, 1, 0, 0, 0, 0, 0);               // Int alone
    repeat (4) step(1, 1, 1, 0, 0, 0, 0);               // alternation
    step(1, 1, 0, 1, 0, 0, 0);                          // mul pulse, Int continuous
    repeat (6) step(1, 1, 0, 0, 0, 0, 0);
    repeat (16) step(1, 1, 1, 0, 1, 0, 0);              // div held high
    repeat (2) step(1, 0, 0, 0, 0, 0, 0);

    step(0, 0, 0, 0, 0, 0, 0);                          // slot clash
    step(1, 0, 0, 0, 1, 0, 0);
    repeat (2) step(1, 0, 0, 0, 0, 0, 0);
    repeat (2) step(1, 0, 0, 1, 0, 0, 0);
    repeat (10) step(1, 1, 1, 0, 0, 0, 0);

    step(1, 1, 0, 0, 0, 1, 0);                          // flush blocks Int
    step(1, 0, 0, 0, 0, 0, 1);                          // unbooked Mul_Done
    repeat (3) step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0);                          // book, then reset mid-flight
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    repeat (9) step(1, 1, 1, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) >= 1), ($urandom_range(0, 99) < 60),
           ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 10),
           ($urandom_range(0, 299) == 0));
    end

    @(negedge Clk);
    #1;
    if (sbq.size() != 0) begin
      nMis++;
      $display("FAIL drain pending got %0d want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
